// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST sequencer: state encoding, default sizing
// constants and a constant-evaluable ceiling-log2 used for counter widths.
// ---------------------------------------------------------------------------
package bist_pkg;

    localparam int unsigned SHIFT_LEN_DEF = 26;
    localparam int unsigned NUM_SEQ_DEF   = 500;
    localparam int unsigned STATE_W       = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } bist_state_t;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    // Counter width that is never zero.
    function automatic int unsigned cnt_w(input int unsigned v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/bist_start_sync.sv
// ---------------------------------------------------------------------------
// bist_start_sync
// Brings the asynchronous start level into the clock domain and turns its
// rising edge into a single registered new_seq pulse, accepted only while the
// sequencer is idle (IDLE or DONE).
// Ports:
//   clock      system clock
//   reset      asynchronous active-high reset
//   i_start    raw asynchronous start level
//   i_idle     sequencer can accept a start (IDLE or DONE)
//   o_new_seq  one-cycle start pulse (registered)
// ---------------------------------------------------------------------------
module bist_start_sync (
    input  logic clock,
    input  logic reset,
    input  logic i_start,
    input  logic i_idle,
    output logic o_new_seq
);

    // r_meta/r_s1 form the synchroniser; r_s2 is the delayed copy for edge detect.
    logic r_meta;
    logic r_s1;
    logic r_s2;
    logic w_edge;

    assign w_edge = r_s1 & ~r_s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta    <= 1'b0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            o_new_seq <= 1'b0;
        end else begin
            r_meta    <= i_start;
            r_s1      <= r_meta;
            r_s2      <= r_s1;
            // Edges seen while a run is in progress are dropped, not queued.
            o_new_seq <= w_edge & i_idle;
        end
    end

endmodule

// File: rtl/bist_controller_param.sv
// ---------------------------------------------------------------------------
// bist_controller_param
// Per-scan BIST sequencer: on a start pulse runs lim sequences of SHIFT_LEN
// shift cycles separated by CAPTURE_CYC capture cycles, then a one-cycle
// signature check recording pass/fail. A mid-run abort jumps straight to DONE.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   bist_start     asynchronous start level (rising edge starts a run)
//   bist_abort     synchronous abort request
//   seq_limit      requested sequence count, sampled at start
//   sig_match      MISR compare result, sampled in CHECK
//   new_seq        start-of-run pulse
//   scan_en, capture, sig_check, bist_running, bist_end  state decodes
//   bist_pass, bist_aborted  registered result flags
//   seq_count      completed shift phases in current/last run
// ---------------------------------------------------------------------------
module bist_controller_param
    import bist_pkg::*;
#(
    parameter  int unsigned SHIFT_LEN   = SHIFT_LEN_DEF,
    parameter  int unsigned NUM_SEQ     = NUM_SEQ_DEF,
    parameter  int unsigned CAPTURE_CYC = 1,
    localparam int unsigned SEQ_W       = clog2(NUM_SEQ + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bist_start,
    input  logic             bist_abort,
    input  logic [SEQ_W-1:0] seq_limit,
    input  logic             sig_match,
    output logic             new_seq,
    output logic             scan_en,
    output logic             capture,
    output logic             sig_check,
    output logic             bist_running,
    output logic             bist_end,
    output logic             bist_pass,
    output logic             bist_aborted,
    output logic [SEQ_W-1:0] seq_count
);

    localparam int unsigned PER_W = cnt_w(SHIFT_LEN);
    localparam int unsigned CAP_W = cnt_w(CAPTURE_CYC);

    bist_state_t      r_state;
    logic [PER_W-1:0] r_per_count;
    logic [CAP_W-1:0] r_cap_count;
    logic [SEQ_W-1:0] r_lim;
    logic [SEQ_W-1:0] r_seq_count;
    logic             r_pass;
    logic             r_aborted;

    logic             w_idle;
    logic             w_new_seq;
    logic [SEQ_W-1:0] w_lim;
    logic [SEQ_W-1:0] w_seq_inc;

    assign w_idle = (r_state == IDLE) || (r_state == DONE);

    bist_start_sync u_start_sync (
        .clock     (clock),
        .reset     (reset),
        .i_start   (bist_start),
        .i_idle    (w_idle),
        .o_new_seq (w_new_seq)
    );

    // Out-of-range or zero requests fall back to the full sequence count.
    assign w_lim = ((seq_limit == '0) || (seq_limit > SEQ_W'(NUM_SEQ)))
                   ? SEQ_W'(NUM_SEQ) : seq_limit;
    assign w_seq_inc = r_seq_count + SEQ_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_per_count <= '0;
            r_cap_count <= '0;
            r_lim       <= '0;
            r_seq_count <= '0;
            r_pass      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    // Start wins over a simultaneous abort here.
                    if (w_new_seq) begin
                        r_state     <= SHIFT;
                        r_per_count <= '0;
                        r_cap_count <= '0;
                        r_seq_count <= '0;
                        r_lim       <= w_lim;
                        r_pass      <= 1'b0;
                        r_aborted   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bist_abort) begin
                        r_state   <= DONE;
                        r_pass    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (r_per_count == PER_W'(SHIFT_LEN - 1)) begin
                        r_per_count <= '0;
                        r_seq_count <= w_seq_inc;
                        r_state     <= (w_seq_inc == r_lim) ? CHECK : CAPTURE;
                    end else begin
                        r_per_count <= r_per_count + PER_W'(1);
                    end
                end
                CAPTURE: begin
                    if (bist_abort) begin
                        r_state   <= DONE;
                        r_pass    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (r_cap_count == CAP_W'(CAPTURE_CYC - 1)) begin
                        r_cap_count <= '0;
                        r_state     <= SHIFT;
                    end else begin
                        r_cap_count <= r_cap_count + CAP_W'(1);
                    end
                end
                CHECK: begin
                    r_state <= DONE;
                    if (bist_abort) begin
                        r_pass    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else begin
                        r_pass <= sig_match;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Moore decodes straight off the state register.
    assign new_seq      = w_new_seq;
    assign scan_en      = (r_state == SHIFT);
    assign capture      = (r_state == CAPTURE);
    assign sig_check    = (r_state == CHECK);
    assign bist_running = (r_state == SHIFT) || (r_state == CAPTURE) || (r_state == CHECK);
    assign bist_end     = (r_state == DONE);
    assign bist_pass    = r_pass;
    assign bist_aborted = r_aborted;
    assign seq_count    = r_seq_count;

endmodule

// File: doc/bist_controller_param.md
Name: bist_controller_param

Overview:
Parametrised second-generation BIST sequencer for per-scan BIST.
- On a rising edge of bist_start it runs a programmable number of test sequences. Each sequence is a scan-shift phase of SHIFT_LEN cycles; sequences are separated by a capture phase of CAPTURE_CYC cycles.
- After the last sequence it requests a one-cycle signature check and records pass/fail. It supports mid-run abort.
- Sits between the top-level BIST start/abort control and the LFSR/scan-chain/MISR datapath.

Parameters:
- SHIFT_LEN, 26, scan-shift cycles per sequence; legal value >= 1.
- NUM_SEQ, 500, maximum and default number of sequences; legal value >= 1.
- CAPTURE_CYC, 1, capture cycles between consecutive sequences; legal value >= 1.
- SEQ_W, derived localparam = clog2(NUM_SEQ+1), width of the sequence counter.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- bist_start  in  1  start request; asynchronous level, acted on at its rising edge.
- bist_abort  in  1  synchronous abort request; level-sensitive.
- seq_limit  in  SEQ_W  requested number of sequences; sampled when a run starts.
- sig_match  in  1  MISR signature-compare result; sampled in the CHECK state.
- new_seq  out  1  one-cycle pulse marking the start of a run.
- scan_en  out  1  high in SHIFT.
- capture  out  1  high in CAPTURE.
- sig_check  out  1  high in CHECK.
- bist_running  out  1  high in SHIFT, CAPTURE or CHECK.
- bist_end  out  1  high in DONE.
- bist_pass  out  1  registered pass flag.
- bist_aborted  out  1  registered flag: last run was aborted.
- seq_count  out  SEQ_W  number of completed shift phases in the current or last run.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - state = IDLE; all counters = 0.
  - Sync flops = 0.
  - All outputs = 0.
- Start detection:
  - bist_start passes through a 2-FF synchroniser (s1, s2).
  - Edge = s1 & ~s2.
  - new_seq is registered as edge, gated so it is 1 only when state is IDLE or DONE.
  - Latency: 3 rising edges from bist_start rise to new_seq high.
  - Start edges while bist_running = 1 are dropped, not queued.
- Limit latch:
  - On the cycle new_seq = 1, register lim = seq_limit.
  - If seq_limit = 0 or seq_limit > NUM_SEQ, lim = NUM_SEQ.
  - seq_limit is ignored at all other times.
- State machine (Moore; scan_en, capture, sig_check, bist_running, bist_end decode from state only):
  - IDLE:
    - new_seq -> SHIFT.
    - On that edge: clear seq_count and per_count; clear bist_pass and bist_aborted.
  - SHIFT:
    - per_count increments each cycle.
    - On the cycle per_count = SHIFT_LEN-1: seq_count increments and per_count clears.
    - If seq_count+1 = lim -> CHECK, else -> CAPTURE.
  - CAPTURE:
    - cap_count increments each cycle.
    - On the cycle cap_count = CAPTURE_CYC-1: cap_count clears -> SHIFT.
  - CHECK:
    - Lasts 1 cycle; bist_pass <= sig_match.
    - -> DONE.
  - DONE:
    - Outputs seq_count, bist_pass and bist_aborted hold.
    - new_seq -> SHIFT, with the same clears as from IDLE.
- Run duration:
  - bist_running is high for lim*SHIFT_LEN + (lim-1)*CAPTURE_CYC + 1 cycles.
  - scan_en rises the cycle after new_seq.
- Abort:
  - bist_abort = 1 in SHIFT, CAPTURE or CHECK -> DONE on the next edge.
  - On that edge: bist_aborted <= 1, bist_pass <= 0.
  - seq_count freezes; CHECK is skipped.
  - Abort has priority over all other SHIFT/CAPTURE/CHECK transitions, including the sig_match sample in CHECK.
  - Abort is ignored in IDLE and DONE.
  - new_seq and bist_abort together in DONE: start wins.
- Counters:
  - per_count width = clog2(SHIFT_LEN), minimum 1.
  - cap_count width = clog2(CAPTURE_CYC), minimum 1.
  - No counter ever wraps; terminal compares are exact.
- Illegal state encodings -> IDLE.

Decomposition:
- Shared package bist_pkg:
  - state encoding localparams IDLE=0, SHIFT=1, CAPTURE=2, CHECK=3, DONE=4 (3 bits);
  - clog2 constant function;
  - default constants SHIFT_LEN_DEF=26, NUM_SEQ_DEF=500.
- One sub-module, bist_start_sync: 2-FF synchroniser, edge detect, idle gating, producing new_seq. It also uses the asynchronous reset.

Test Plan:
1. SHIFT_LEN=4, CAPTURE_CYC=1, seq_limit=3, pulse bist_start:
   - new_seq high exactly 1 cycle;
   - scan_en high in 3 bursts of 4 cycles, separated by 1-cycle capture;
   - sig_check 1 cycle;
   - bist_running high 15 cycles; bist_end high; seq_count=3.
2. Same configuration as 1, sig_match=1 during CHECK -> bist_pass=1. Rerun with sig_match=0 -> bist_pass=0, and bist_pass clears on the restart edge.
3. Assert bist_abort for 1 cycle during the 2nd SHIFT burst:
   - next cycle: DONE, bist_aborted=1, bist_pass=0, seq_count=1;
   - no sig_check pulse.
4. NUM_SEQ=5, seq_limit=0, then seq_limit=7 -> both runs execute 5 shift bursts; seq_count=5.
5. Assert reset asynchronously mid-SHIFT:
   - all outputs 0 before the next clock edge;
   - after release, a new start edge runs a full, correct sequence.
6. Toggle bist_start while running -> no new_seq and no restart. From DONE, a new start clears bist_end, bist_aborted and bist_pass, and a fresh run completes.
